gpio_input_debounce: RTL and testbench
======================================

// Module: gpio_input_debounce
// PURPOSE
//  Conditioning stage directly upstream of the GPIO input register: synchronises the 8 raw input pins,
//  debounces each one, and detects per-pin rising/falling edges. Drives the GPIO block's INPUT_PINS
//  with clean levels. Raises a level IRQ to the CPU interrupt controller from a bus-visible pending register.
// PARAMETERS
//  BITS            16        bus data width
//  ADDRESS_BITS    8         bus address width
//  CLK_FREQ        12000000  clock frequency, informational only
//  DEBOUNCE_CYCLES 120000    consecutive stable cycles (N) needed to accept a level change; >=1
// PORTS
//  CLK          in   1             system clock
//  RSTb         in   1             asynchronous active-low reset
//  ADDRESS      in   ADDRESS_BITS  register select
//  DATA_IN      in   BITS          write data
//  DATA_OUT     out  BITS          read data, combinational from ADDRESS
//  WR           in   1             write strobe, sampled on the CLK rising edge
//  RAW_PINS     in   8             asynchronous pad inputs
//  CLEAN_PINS   out  8             debounced levels; feed the GPIO block's INPUT_PINS
//  IRQ          out  1             high while any pending bit is set
// BEHAVIOUR
//  - Reset (RSTb low, asynchronous) clears everything: sync flops, counters, debounced state, RISE_EN,
//    FALL_EN and PENDING all go to 0. CLEAN_PINS=0, IRQ=0, DATA_OUT=0 (for address 0x00).
//  - Synchroniser: two flops per pin, sync_a <= RAW_PINS and sync_b <= sync_a.
//  - Debounce, per pin i, with counter width clog2(N+1):
//      sync_b[i]==db[i]        -> cnt<=0
//      else if cnt==N-1        -> db[i]<=sync_b[i], cnt<=0
//      else                    -> cnt<=cnt+1
//    A glitch shorter than N cycles never reaches db. Latency from a clean pin step to CLEAN_PINS
//    is 2+N rising edges. CLEAN_PINS = db (registered, no combinational path from RAW_PINS).
//  - Edges: rise[i]=~db[i]&db_next[i]; fall[i]=db[i]&~db_next[i].
//  - PENDING[i] is set on the same edge that db changes, if (rise&RISE_EN)|(fall&FALL_EN).
//  - Register map (reads are zero-extended to BITS; other addresses read 0 and ignore writes):
//      0x00 STATE    RO  db[7:0]
//      0x01 RISE_EN  RW  [7:0]
//      0x02 FALL_EN  RW  [7:0]
//      0x03 PENDING  R/W1C: a write clears the bits where DATA_IN[7:0] is 1
//      0x04 RAWSYNC  RO  sync_b[7:0], diagnostic
//  - Same-cycle W1C and set on one bit: the set wins, so no edge is lost.
//  - Enable writes take effect on events from the following cycle onward. Clearing an enable
//    leaves an already-pending bit set.
//  - IRQ = |PENDING, taken from registers, so it is glitch-free. IRQ is 1 the cycle after PENDING is set.
//  - Reset mid-debounce discards the partial count; the pin must be stable for a full N cycles again.
// STRUCTURE
//  - Package gpio_pkg holds:
//      GPIO_IN_STATE/RISE_EN/FALL_EN/PENDING/RAWSYNC address constants
//      GPIO_PIN_COUNT=8
//  - Sub-module gpio_debounce_bit (sync + counter + db flop, outputs db and db_next) is generated
//    8 times. The top level holds the registers, edge logic and bus decode.
// TESTING (DEBOUNCE_CYCLES=4 unless noted)
//  1. Reset, then read all addresses.
//     -> 0x0000 everywhere; IRQ=0; CLEAN_PINS=0x00.
//  2. RAW_PINS 0x00->0x01 held.
//     -> CLEAN_PINS[0]=1 exactly 6 edges later; STATE reads 0x0001.
//  3. RAW_PINS[3] pulses high for 3 cycles.
//     -> CLEAN_PINS unchanged; PENDING=0x00.
//  4. RISE_EN=0x01 written, then pin 0 rises.
//     -> PENDING=0x01 and IRQ=1. Write 0x01 to 0x03 -> PENDING=0x00, IRQ=0 the next cycle.
//  5. FALL_EN=0x80, then pin 7 falls and W1C 0x80 land on the same edge.
//     -> PENDING[7] stays 1.
//  6. Assert RSTb low while pin 2 is 2 cycles into its count.
//     -> all state 0 immediately. After release, pin 2 needs a full 6 edges.

Source files
------------

// File: rtl/gpio_pkg.sv
// GPIO input conditioning: shared constants.
// Register addresses and pin count used by the debounce block.
package gpio_pkg;

  localparam int unsigned GPIO_PIN_COUNT = 8;

  localparam int unsigned GPIO_IN_STATE   = 32'h00;
  localparam int unsigned GPIO_IN_RISE_EN = 32'h01;
  localparam int unsigned GPIO_IN_FALL_EN = 32'h02;
  localparam int unsigned GPIO_IN_PENDING = 32'h03;
  localparam int unsigned GPIO_IN_RAWSYNC = 32'h04;

endpackage

// File: rtl/gpio_debounce_bit.sv
// One pin: two-flop synchroniser, stability counter, debounced level.
// db_next_o is the level db_o will take on the coming edge.
module gpio_debounce_bit #(
  parameter int unsigned N = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic sync_o,
  output logic db_o,
  output logic db_next_o
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);

  logic          sync_a_q;
  logic          sync_b_q;
  logic          db_q;
  logic          db_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count consecutive cycles the synced level differs from db.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (sync_b_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      db_d  = sync_b_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchroniser, counter and debounced level registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_a_q <= 1'b0;
      sync_b_q <= 1'b0;
      db_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_a_q <= raw_i;
      sync_b_q <= sync_a_q;
      db_q     <= db_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sync_o    = sync_b_q;
  assign db_o      = db_q;
  assign db_next_o = db_d;

endmodule

// File: rtl/gpio_input_debounce.sv
// GPIO input conditioning: per-pin debounce, edge detect,
// bus-visible enables and W1C pending register driving IRQ.
module gpio_input_debounce
  import gpio_pkg::*;
#(
  parameter int unsigned BITS            = 16,
  parameter int unsigned ADDRESS_BITS    = 8,
  parameter int unsigned CLK_FREQ        = 12000000,
  parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
  input  logic                    CLK,
  input  logic                    RSTb,
  input  logic [ADDRESS_BITS-1:0] ADDRESS,
  input  logic [BITS-1:0]         DATA_IN,
  output logic [BITS-1:0]         DATA_OUT,
  input  logic                    WR,
  input  logic [7:0]              RAW_PINS,
  output logic [7:0]              CLEAN_PINS,
  output logic                    IRQ
);

  localparam int unsigned P = GPIO_PIN_COUNT;

  logic [P-1:0] sync_b;
  logic [P-1:0] db;
  logic [P-1:0] db_next;
  logic [P-1:0] rise;
  logic [P-1:0] fall;
  logic [P-1:0] set;
  logic [P-1:0] clr;

  logic [P-1:0] rise_en_q;
  logic [P-1:0] rise_en_d;
  logic [P-1:0] fall_en_q;
  logic [P-1:0] fall_en_d;
  logic [P-1:0] pend_q;
  logic [P-1:0] pend_d;

  logic sel_state;
  logic sel_rise;
  logic sel_fall;
  logic sel_pend;
  logic sel_raw;

  logic [P-1:0]    rdata;
  logic [BITS-1:0] unused_data;

  assign unused_data = DATA_IN;

  for (genvar i = 0; i < P; i++) begin : g_pin
    gpio_debounce_bit #(
      .N(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk_i    (CLK),
      .rst_ni   (RSTb),
      .raw_i    (RAW_PINS[i]),
      .sync_o   (sync_b[i]),
      .db_o     (db[i]),
      .db_next_o(db_next[i])
    );
  end

  assign rise = ~db & db_next;
  assign fall = db & ~db_next;
  assign set  = (rise & rise_en_q) | (fall & fall_en_q);

  assign sel_state = (ADDRESS == ADDRESS_BITS'(GPIO_IN_STATE));
  assign sel_rise  = (ADDRESS == ADDRESS_BITS'(GPIO_IN_RISE_EN));
  assign sel_fall  = (ADDRESS == ADDRESS_BITS'(GPIO_IN_FALL_EN));
  assign sel_pend  = (ADDRESS == ADDRESS_BITS'(GPIO_IN_PENDING));
  assign sel_raw   = (ADDRESS == ADDRESS_BITS'(GPIO_IN_RAWSYNC));

  // Register writes; a new edge outranks a same-cycle W1C.
  always_comb begin
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    clr       = '0;
    if (WR && sel_rise) rise_en_d = DATA_IN[P-1:0];
    if (WR && sel_fall) fall_en_d = DATA_IN[P-1:0];
    if (WR && sel_pend) clr = DATA_IN[P-1:0];
    pend_d = (pend_q & ~clr) | set;
  end

  // Control and status registers.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
    end else begin
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      pend_q    <= pend_d;
    end
  end

  // Read mux; unmapped addresses return zero.
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_state: rdata = db;
      sel_rise:  rdata = rise_en_q;
      sel_fall:  rdata = fall_en_q;
      sel_pend:  rdata = pend_q;
      sel_raw:   rdata = sync_b;
      default:   rdata = '0;
    endcase
  end

  assign DATA_OUT   = BITS'(rdata);
  assign CLEAN_PINS = db;
  assign IRQ        = |pend_q;

endmodule

// File: tb/tb_gpio_input_debounce.sv
// Directed bench for gpio_input_debounce with N=4.
// Inputs change 1ns after a rising edge; outputs checked there too.
module tb_gpio_input_debounce;

  localparam int unsigned BITS = 16;
  localparam int unsigned AB   = 8;

  logic            CLK;
  logic            RSTb;
  logic [AB-1:0]   ADDRESS;
  logic [BITS-1:0] DATA_IN;
  logic [BITS-1:0] DATA_OUT;
  logic            WR;
  logic [7:0]      RAW_PINS;
  logic [7:0]      CLEAN_PINS;
  logic            IRQ;

  int checks;
  int failures;

  gpio_input_debounce #(
    .BITS           (BITS),
    .ADDRESS_BITS   (AB),
    .CLK_FREQ       (12000000),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLK       (CLK),
    .RSTb      (RSTb),
    .ADDRESS   (ADDRESS),
    .DATA_IN   (DATA_IN),
    .DATA_OUT  (DATA_OUT),
    .WR        (WR),
    .RAW_PINS  (RAW_PINS),
    .CLEAN_PINS(CLEAN_PINS),
    .IRQ       (IRQ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [15:0] d);
    ADDRESS = a;
    DATA_IN = d;
    WR      = 1'b1;
    tick(1);
    WR      = 1'b0;
    DATA_IN = '0;
    ADDRESS = '0;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [15:0] d);
    ADDRESS = a;
    #1;
    d = DATA_OUT;
    ADDRESS = '0;
  endtask

  task automatic test_reset();
    logic [15:0] rd;
    logic [7:0]  addrs [7];
    addrs = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hFF};
    RSTb = 1'b0;
    tick(3);
    RSTb = 1'b1;
    tick(1);
    for (int i = 0; i < 7; i++) begin
      bus_rd(addrs[i], rd);
      checks++;
      if (rd !== 16'h0000) begin
        failures++;
        $display("FAIL reset_rd a=%02h got=%04h exp=0000", addrs[i], rd);
      end
    end
    checks++;
    if (IRQ !== 1'b0) begin
      failures++;
      $display("FAIL reset_irq got=%b exp=0", IRQ);
    end
    checks++;
    if (CLEAN_PINS !== 8'h00) begin
      failures++;
      $display("FAIL reset_clean got=%02h exp=00", CLEAN_PINS);
    end
  endtask

  task automatic test_step();
    logic [15:0] rd;
    RAW_PINS = 8'h01;
    tick(5);
    checks++;
    if (CLEAN_PINS !== 8'h00) begin
      failures++;
      $display("FAIL step_early got=%02h exp=00", CLEAN_PINS);
    end
    tick(1);
    checks++;
    if (CLEAN_PINS !== 8'h01) begin
      failures++;
      $display("FAIL step_edge6 got=%02h exp=01", CLEAN_PINS);
    end
    bus_rd(8'h00, rd);
    checks++;
    if (rd !== 16'h0001) begin
      failures++;
      $display("FAIL step_state got=%04h exp=0001", rd);
    end
    bus_rd(8'h04, rd);
    checks++;
    if (rd !== 16'h0001) begin
      failures++;
      $display("FAIL step_rawsync got=%04h exp=0001", rd);
    end
    bus_rd(8'h03, rd);
    checks++;
    if (rd !== 16'h0000 || IRQ !== 1'b0) begin
      failures++;
      $display("FAIL step_pend got=%04h irq=%b exp=0000/0", rd, IRQ);
    end
  endtask

  task automatic test_glitch();
    logic [15:0] rd;
    int bad;
    bad = 0;
    RAW_PINS = 8'h09;
    tick(3);
    RAW_PINS = 8'h01;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (CLEAN_PINS !== 8'h01) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL glitch_clean bad=%0d got=%02h exp=01", bad, CLEAN_PINS);
    end
    bus_rd(8'h03, rd);
    checks++;
    if (rd !== 16'h0000) begin
      failures++;
      $display("FAIL glitch_pend got=%04h exp=0000", rd);
    end
  endtask

  task automatic test_rise_irq();
    logic [15:0] rd;
    RAW_PINS = 8'h00;
    tick(8);
    checks++;
    if (CLEAN_PINS !== 8'h00 || IRQ !== 1'b0) begin
      failures++;
      $display("FAIL fall_noen got=%02h irq=%b exp=00/0", CLEAN_PINS, IRQ);
    end
    bus_wr(8'h01, 16'h0001);
    bus_rd(8'h01, rd);
    checks++;
    if (rd !== 16'h0001) begin
      failures++;
      $display("FAIL rise_en_rd got=%04h exp=0001", rd);
    end
    RAW_PINS = 8'h01;
    tick(5);
    checks++;
    if (IRQ !== 1'b0) begin
      failures++;
      $display("FAIL rise_irq_early got=%b exp=0", IRQ);
    end
    tick(1);
    bus_rd(8'h03, rd);
    checks++;
    if (rd !== 16'h0001 || IRQ !== 1'b1) begin
      failures++;
      $display("FAIL rise_pend got=%04h irq=%b exp=0001/1", rd, IRQ);
    end
    bus_wr(8'h03, 16'h0001);
    bus_rd(8'h03, rd);
    checks++;
    if (rd !== 16'h0000 || IRQ !== 1'b0) begin
      failures++;
      $display("FAIL w1c_clear got=%04h irq=%b exp=0000/0", rd, IRQ);
    end
  endtask

  task automatic test_same_edge();
    logic [15:0] rd;
    bus_wr(8'h02, 16'h0080);
    bus_rd(8'h02, rd);
    checks++;
    if (rd !== 16'h0080) begin
      failures++;
      $display("FAIL fall_en_rd got=%04h exp=0080", rd);
    end
    RAW_PINS = 8'h81;
    tick(6);
    bus_rd(8'h03, rd);
    checks++;
    if (CLEAN_PINS !== 8'h81 || rd !== 16'h0000) begin
      failures++;
      $display("FAIL p7_rise clean=%02h pend=%04h exp=81/0000",
               CLEAN_PINS, rd);
    end
    RAW_PINS = 8'h01;
    tick(5);
    bus_wr(8'h03, 16'h0080);
    bus_rd(8'h03, rd);
    checks++;
    if (CLEAN_PINS !== 8'h01 || rd !== 16'h0080 || IRQ !== 1'b1) begin
      failures++;
      $display("FAIL set_wins clean=%02h pend=%04h irq=%b exp=01/0080/1",
               CLEAN_PINS, rd, IRQ);
    end
    bus_wr(8'h03, 16'h0080);
    bus_rd(8'h03, rd);
    checks++;
    if (rd !== 16'h0000 || IRQ !== 1'b0) begin
      failures++;
      $display("FAIL p7_clear got=%04h irq=%b exp=0000/0", rd, IRQ);
    end
    bus_wr(8'h05, 16'hFFFF);
    bus_wr(8'h00, 16'hFFFF);
    bus_rd(8'h05, rd);
    checks++;
    if (rd !== 16'h0000) begin
      failures++;
      $display("FAIL unmapped_rd got=%04h exp=0000", rd);
    end
    bus_rd(8'h00, rd);
    checks++;
    if (rd !== 16'h0001) begin
      failures++;
      $display("FAIL state_ro got=%04h exp=0001", rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] rd;
    RAW_PINS = 8'h05;
    tick(4);
    RSTb = 1'b0;
    #1;
    bus_rd(8'h01, rd);
    checks++;
    if (CLEAN_PINS !== 8'h00 || IRQ !== 1'b0 || rd !== 16'h0000) begin
      failures++;
      $display("FAIL rst_mid clean=%02h irq=%b rise_en=%04h exp=00/0/0000",
               CLEAN_PINS, IRQ, rd);
    end
    tick(1);
    RSTb = 1'b1;
    tick(5);
    checks++;
    if (CLEAN_PINS !== 8'h00) begin
      failures++;
      $display("FAIL rst_mid_early got=%02h exp=00", CLEAN_PINS);
    end
    tick(1);
    checks++;
    if (CLEAN_PINS !== 8'h05) begin
      failures++;
      $display("FAIL rst_mid_full got=%02h exp=05", CLEAN_PINS);
    end
    bus_rd(8'h03, rd);
    checks++;
    if (rd !== 16'h0000 || IRQ !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_pend got=%04h irq=%b exp=0000/0", rd, IRQ);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RSTb     = 1'b0;
    ADDRESS  = '0;
    DATA_IN  = '0;
    WR       = 1'b0;
    RAW_PINS = 8'h00;
    test_reset();
    test_step();
    test_glitch();
    test_rise_irq();
    test_same_edge();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
